// File: rtl/k_fetch_unit.sv
// k_fetch_unit: instruction fetch stage ahead of K_InstructionMemory.
// Owns the word-addressed PC, captures {pc, instr} into a small prefetch
// queue and hands the queue head to decode. A redirect flushes the queue and
// reloads the PC.
//
// Handshake (valid/ready): the head entry transfers on a rising edge where
// out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0, out_pc and
// out_instr are held stable; only a redirect or reset may withdraw them.
// out_valid is never made to depend on out_ready.
module k_fetch_unit #(
  parameter int                  ADDR_W   = 32,
  parameter int                  DATA_W   = 32,
  parameter int                  DEPTH    = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_instr,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  input  logic                       out_ready,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Queue storage; contents are don't-care while unoccupied, so no reset.
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  logic [ADDR_W-1:0] pc_q;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count_q;

  logic pop;
  logic push;

  // Transfer qualifiers; a full queue accepts a fetch only alongside a pop.
  always_comb begin
    pop  = out_valid & out_ready;
    push = en & ~redirect_valid & (~full | pop);
  end

  // Outputs come only from registered state; heads are zeroed when empty.
  always_comb begin
    imem_addr = pc_q;
    count     = count_q;
    full      = (count_q == DEPTH_C);
    out_valid = (count_q != '0);
    out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
    out_instr = out_valid ? instr_mem[rd_ptr] : '0;
  end

  // Capture the fetched word together with the PC that addressed it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc_q;
      instr_mem[wr_ptr] <= imem_instr;
    end
  end

  // PC, pointers and occupancy: reset > redirect > push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (redirect_valid) begin
      // Any pop this cycle was seen by decode; the flush discards the rest.
      pc_q    <= redirect_pc;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        pc_q   <= pc_q + ADDR_W'(1);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_k_fetch_unit.sv
// Directed bench for k_fetch_unit: two instances share the stimulus, one with
// RESET_PC=0 and one with RESET_PC=FFFF_FFFE to exercise PC wrap.
module tb_k_fetch_unit;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  // Clock / reset and shared stimulus
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              en;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_ready;

  // Instance A (RESET_PC = 0)
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_instr;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              full;
  logic [2:0]        count;

  // Instance B (RESET_PC = FFFF_FFFE)
  logic [ADDR_W-1:0] imem_addr_b;
  logic [DATA_W-1:0] imem_instr_b;
  logic              out_valid_b;
  logic [DATA_W-1:0] out_instr_b;
  logic [ADDR_W-1:0] out_pc_b;
  logic              full_b;
  logic [2:0]        count_b;

  // Memory model: instruction word is a tag OR'd with its address.
  assign imem_instr   = 32'hA000_0000 | imem_addr;
  assign imem_instr_b = 32'hA000_0000 | imem_addr_b;

  k_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .full(full), .count(count)
  );

  k_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFE)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .imem_addr(imem_addr_b), .imem_instr(imem_instr_b),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid_b), .out_instr(out_instr_b), .out_pc(out_pc_b),
    .out_ready(out_ready), .full(full_b), .count(count_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard of expected head PCs for the in-order drain
  logic [ADDR_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
  endtask

  logic [ADDR_W-1:0] exp_pc;

  initial begin
    do_reset();

    // Reset state
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_full", full, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc", out_pc, 0);
    check("rst_addr_b", imem_addr_b, 32'hFFFF_FFFE);

    // 1: streaming with decode always ready
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1;
    #1;
    check("t1_valid_pre", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_valid", out_valid, 1);
      check("t1_pc", out_pc, k);
      check("t1_instr", out_instr, 32'hA000_0000 | k);
      check("t1_count", count, 1);
    end

    // 5: wrap on the second instance, stimulated by the same sequence
    do_reset();
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1;
    exp_pc = 32'hFFFF_FFFE;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t5_pc_b", out_pc_b, exp_pc);
      check("t5_instr_b", out_instr_b, 32'hA000_0000 | exp_pc);
      exp_pc = exp_pc + 32'd1;
    end

    // 2: decode stalls for 6 cycles; queue fills and holds
    do_reset();
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t2_hold_pc", out_pc, 0);
    end
    check("t2_count", count, 4);
    check("t2_full", full, 1);
    check("t2_addr", imem_addr, 4);

    // 2/3: drain in order while still fetching at full occupancy
    for (int k = 0; k < 6; k++) exp_q.push_back(ADDR_W'(k));
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_pc = exp_q.pop_front();
      check("t2_order_pc", out_pc, exp_pc);
      check("t2_order_instr", out_instr, 32'hA000_0000 | exp_pc);
      check("t3_count", count, 4);
      check("t3_addr", imem_addr, 4 + k);
      step();
    end
    // Queue now holds pcs 6..9, fetch address 10.

    // 4: trim to 3 entries, then redirect while stalled
    en = 1'b0; out_ready = 1'b1;
    step();
    check("t4_count3", count, 3);
    check("t4_head", out_pc, 7);
    check("t4_addr_hold", imem_addr, 10);
    en = 1'b1; out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0; redirect_pc = '0;
    check("t4_valid", out_valid, 0);
    check("t4_count", count, 0);
    check("t4_addr", imem_addr, 32'h100);
    check("t4_zero_pc", out_pc, 0);
    check("t4_zero_instr", out_instr, 0);
    out_ready = 1'b1;
    step();
    check("t4_pc0", out_pc, 32'h100);
    check("t4_instr0", out_instr, 32'hA000_0100);
    step();
    check("t4_pc1", out_pc, 32'h101);

    // en=0: PC holds and the queue drains to empty
    en = 1'b0;
    step();
    check("en0_valid", out_valid, 0);
    check("en0_count", count, 0);
    check("en0_addr", imem_addr, 32'h102);

    // 6: reset beats a simultaneous redirect and pop
    en = 1'b1; out_ready = 1'b1;
    step(); step(); step();
    check("t6_pre_valid", out_valid, 1);
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h55;
    step();
    check("t6_count", count, 0);
    check("t6_valid", out_valid, 0);
    check("t6_addr", imem_addr, 0);
    check("t6_instr", out_instr, 0);
    check("t6_full", full, 0);
    check("t6_addr_b", imem_addr_b, 32'hFFFF_FFFE);
    rst_n = 1'b1; redirect_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
